axi_ni_response_dispatcher: RTL and testbench
=============================================

AXI_NI_RESPONSE_DISPATCHER -- requirements
Module: axi_ni_response_dispatcher

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 32: NoC flit width, passed to the pinout stage.
REQ-002 SHALL have parameter AXIRDATAWD, default 32: AXI read data width.
REQ-003 SHALL have parameter BURSTLENWD, default 8: burst length field width, encoded as beats-1.
REQ-004 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port hdr_valid, input, 1: the depacketizer holds a decoded response header.
REQ-007 SHALL have port hdr_ready, output, 1: pops the header; it is consumed in cycles where hdr_valid && hdr_ready.
REQ-008 SHALL have port hdr_is_read, input, 1: the header belongs to a read response.
REQ-009 SHALL have port hdr_id, input, `PACKETTRANSIDWD: transaction ID.
REQ-010 SHALL have port hdr_response, input, `PACKETRESPONSEWD: packet response code.
REQ-011 SHALL have port hdr_locked, input, 1: exclusive-access flag.
REQ-012 SHALL have port hdr_len, input, BURSTLENWD: read beats-1; ignored for writes.
REQ-013 SHALL have port data_valid, input, 1: a read data beat is available.
REQ-014 SHALL have port data_in, input, `PACKETREADDATAWD: read beat payload, stable while data_valid.
REQ-015 SHALL have port data_pop, output, 1: consumes the current beat.
REQ-016 SHALL have ports RID/RDATA/RRESP/RVALID/RLAST (outputs) and RREADY (input): the AXI R channel.
REQ-017 SHALL have ports BID/BRESP/BVALID (outputs) and BREADY (input): the AXI B channel.

Function
REQ-018 SHALL implement FSM states IDLE, RBURST and WRESP.
REQ-019 In IDLE, hdr_ready SHALL be 1; on hdr_valid it SHALL capture id/response/locked/is_read/len into registers and go to RBURST if is_read, otherwise to WRESP.
REQ-020 In RBURST, RVALID SHALL equal data_valid.
REQ-021 In RBURST, RDATA SHALL equal data_in and RID/RRESP SHALL be derived from the captured header.
REQ-022 Once asserted, RVALID SHALL NOT deassert until the RVALID && RREADY handshake; data sources hold data_valid until popped.
REQ-023 data_pop SHALL equal RVALID && RREADY (zero added latency).
REQ-024 A beat counter SHALL load hdr_len on capture and decrement on each R handshake; RLAST SHALL be 1 when the counter equals 0 and RVALID=1.
REQ-025 hdr_len=0 SHALL give a 1-beat burst; hdr_len=2^BURSTLENWD-1 SHALL give the maximum burst with no counter wrap.
REQ-026 In WRESP, BVALID SHALL be 1 with BID/BRESP from the captured header; on BREADY, state SHALL go to IDLE.
REQ-027 Back-to-back: in the final R handshake cycle or the B handshake cycle, hdr_ready SHALL be 1; if hdr_valid, the next header SHALL be captured that cycle with no idle bubble.
REQ-028 RRESP/BRESP mapping: DVA+locked -> EXOKAY; DVA+!locked -> OK; FAIL -> OK; other codes -> SLVERR.
REQ-029 The inactive channel SHALL drive ID, DATA and RESP to 0 and VALID to 0.
REQ-030 RREADY/BREADY asserted without the matching VALID SHALL have no effect.
REQ-031 data_valid asserted in IDLE or WRESP SHALL NOT be popped.

Reset
REQ-032 On reset_n=0, state SHALL go to IDLE, counter and captured registers to 0, and RVALID, BVALID, RLAST and data_pop to 0; hdr_ready SHALL become 1 after reset release.
REQ-033 Reset mid-burst SHALL abandon the burst with no further pops; resynchronising the depacketizer is the system's responsibility.

Structure
REQ-034 FSM state encodings and the response-mapping function SHALL live in a shared package alongside the existing NI include constants.
REQ-035 Channel output formatting SHALL be done by one instance of axi_ni_response_pinout_mask.
REQ-036 That instance SHALL be driven with mask_response = !(RBURST && data_valid) && !WRESP and packet_type_is_read = (state==RBURST).

Verification
REQ-037 Read with hdr_len=3, DVA, RREADY=1 -> 4 R beats on consecutive cycles, RLAST on beat 4 only, RRESP=OK, 4 data_pop pulses.
REQ-038 Write with DVA+locked, BREADY low 5 cycles -> BVALID held 5 cycles with stable BID, BRESP=EXOKAY, single handshake, return to IDLE.
REQ-039 Read hdr_len=1, RREADY toggling 1/0 with data_valid gaps -> RVALID never drops before handshake, exactly 2 pops.
REQ-040 Back-to-back read(len 0) then write header -> write header captured in the R handshake cycle, BVALID on the next cycle.
REQ-041 reset_n pulsed low mid-burst after beat 2 of 4 -> RVALID/data_pop 0 immediately, FSM in IDLE, hdr_ready=1 after release.
REQ-042 Response code not DVA/FAIL on read -> RRESP=SLVERR on every beat.

Source files
------------

// File: rtl/axi_ni_response_dispatcher_pkg.sv
// Shared NI constants, dispatcher FSM encodings and the packet-to-AXI response mapping.
package axi_ni_response_dispatcher_pkg;

  localparam int PACKETTRANSIDWD  = 4;
  localparam int PACKETRESPONSEWD = 2;

  typedef logic [PACKETRESPONSEWD-1:0] pkt_resp_t;
  typedef logic [1:0]                  axi_resp_t;

  localparam pkt_resp_t PKT_RESP_DVA    = 2'd0;
  localparam pkt_resp_t PKT_RESP_FAIL   = 2'd1;
  localparam pkt_resp_t PKT_RESP_ERR    = 2'd2;
  localparam pkt_resp_t PKT_RESP_DECERR = 2'd3;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RBURST = 2'd1;
  localparam logic [1:0] ST_WRESP  = 2'd2;

  // A failed exclusive access is reported as plain OKAY, which is how AXI signals exclusive failure.
  function automatic axi_resp_t map_response(input pkt_resp_t resp, input logic locked);
    case (resp)
      PKT_RESP_DVA:  return locked ? AXI_RESP_EXOKAY : AXI_RESP_OKAY;
      PKT_RESP_FAIL: return AXI_RESP_OKAY;
      default:       return AXI_RESP_SLVERR;
    endcase
  endfunction

endpackage

// File: rtl/axi_ni_response_dispatcher_if.sv
// Depacketizer-side header/data handshake plus the AXI R and B channels of the dispatcher.
interface axi_ni_response_dispatcher_if #(
  parameter int AXIRDATAWD = 32,
  parameter int BURSTLENWD = 8
) ();
  import axi_ni_response_dispatcher_pkg::*;

  logic                        hdr_valid;
  logic                        hdr_ready;
  logic                        hdr_is_read;
  logic [PACKETTRANSIDWD-1:0]  hdr_id;
  logic [PACKETRESPONSEWD-1:0] hdr_response;
  logic                        hdr_locked;
  logic [BURSTLENWD-1:0]       hdr_len;
  logic                        data_valid;
  logic [AXIRDATAWD-1:0]       data_in;
  logic                        data_pop;

  logic [PACKETTRANSIDWD-1:0]  RID;
  logic [AXIRDATAWD-1:0]       RDATA;
  logic [1:0]                  RRESP;
  logic                        RVALID;
  logic                        RLAST;
  logic                        RREADY;

  logic [PACKETTRANSIDWD-1:0]  BID;
  logic [1:0]                  BRESP;
  logic                        BVALID;
  logic                        BREADY;

  modport master (
    input  hdr_valid, hdr_is_read, hdr_id, hdr_response, hdr_locked, hdr_len,
    input  data_valid, data_in, RREADY, BREADY,
    output hdr_ready, data_pop, RID, RDATA, RRESP, RVALID, RLAST, BID, BRESP, BVALID
  );

  modport slave (
    output hdr_valid, hdr_is_read, hdr_id, hdr_response, hdr_locked, hdr_len,
    output data_valid, data_in, RREADY, BREADY,
    input  hdr_ready, data_pop, RID, RDATA, RRESP, RVALID, RLAST, BID, BRESP, BVALID
  );

endinterface

// File: rtl/axi_ni_response_pinout_mask.sv
// Formats the AXI R/B outputs: the selected channel is driven, everything else is forced to zero.
module axi_ni_response_pinout_mask
  import axi_ni_response_dispatcher_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int AXIRDATAWD = 32
) (
  input  logic                       i_mask_response,
  input  logic                       i_packet_type_is_read,
  input  logic [PACKETTRANSIDWD-1:0] i_id,
  input  axi_resp_t                  i_resp,
  input  logic [AXIRDATAWD-1:0]      i_data,
  input  logic                       i_last,
  output logic [PACKETTRANSIDWD-1:0] o_rid,
  output logic [AXIRDATAWD-1:0]      o_rdata,
  output logic [1:0]                 o_rresp,
  output logic                       o_rvalid,
  output logic                       o_rlast,
  output logic [PACKETTRANSIDWD-1:0] o_bid,
  output logic [1:0]                 o_bresp,
  output logic                       o_bvalid
);

  localparam int BEAT_FLITS = (AXIRDATAWD + FLIT_WIDTH - 1) / FLIT_WIDTH;

  logic w_r_sel;
  logic w_b_sel;

  assign w_r_sel = !i_mask_response && i_packet_type_is_read;
  assign w_b_sel = !i_mask_response && !i_packet_type_is_read;

  assign o_rvalid = w_r_sel;
  assign o_rlast  = w_r_sel && i_last;
  assign o_rid    = w_r_sel ? i_id : '0;
  assign o_rresp  = w_r_sel ? i_resp : '0;

  assign o_bvalid = w_b_sel;
  assign o_bid    = w_b_sel ? i_id : '0;
  assign o_bresp  = w_b_sel ? i_resp : '0;

  // Read data is gated per flit lane; the top lane may be narrower than a flit.
  genvar gi;
  generate
    for (gi = 0; gi < BEAT_FLITS; gi++) begin : g_lane
      localparam int LO = gi * FLIT_WIDTH;
      localparam int HI = (LO + FLIT_WIDTH > AXIRDATAWD) ? AXIRDATAWD - 1 : LO + FLIT_WIDTH - 1;
      assign o_rdata[HI:LO] = w_r_sel ? i_data[HI:LO] : '0;
    end
  endgenerate

endmodule

// File: rtl/axi_ni_response_dispatcher.sv
// Turns decoded NoC response headers and read beats into AXI R bursts and B responses.
module axi_ni_response_dispatcher
  import axi_ni_response_dispatcher_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int AXIRDATAWD = 32,
  parameter int BURSTLENWD = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  axi_ni_response_dispatcher_if.master  bus
);

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_next;
  logic [PACKETTRANSIDWD-1:0]  r_id;
  logic [PACKETRESPONSEWD-1:0] r_response;
  logic                        r_locked;
  logic [BURSTLENWD-1:0]       r_beat_cnt;

  logic w_r_hs;
  logic w_b_hs;
  logic w_last_beat;
  logic w_capture;
  logic w_mask;

  assign w_r_hs      = bus.RVALID && bus.RREADY;
  assign w_b_hs      = bus.BVALID && bus.BREADY;
  assign w_last_beat = (r_beat_cnt == '0);

  // Ready also in the closing handshake cycle so consecutive responses have no bubble.
  assign bus.hdr_ready = (r_state == ST_IDLE) || (w_r_hs && w_last_beat) || w_b_hs;
  assign w_capture     = bus.hdr_valid && bus.hdr_ready;
  assign bus.data_pop  = w_r_hs;

  assign w_mask = !((r_state == ST_RBURST) && bus.data_valid) && (r_state != ST_WRESP);

  always_comb begin
    w_state_next = r_state;
    if (w_capture) begin
      w_state_next = bus.hdr_is_read ? ST_RBURST : ST_WRESP;
    end else if ((w_r_hs && w_last_beat) || w_b_hs) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_id       <= '0;
      r_response <= '0;
      r_locked   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_id       <= bus.hdr_id;
        r_response <= bus.hdr_response;
        r_locked   <= bus.hdr_locked;
        r_beat_cnt <= bus.hdr_is_read ? bus.hdr_len : '0;
      end else if (w_r_hs && !w_last_beat) begin
        r_beat_cnt <= r_beat_cnt - 1'b1;
      end
    end
  end

  axi_ni_response_pinout_mask #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .AXIRDATAWD (AXIRDATAWD)
  ) u_pinout (
    .i_mask_response       (w_mask),
    .i_packet_type_is_read (r_state == ST_RBURST),
    .i_id                  (r_id),
    .i_resp                (map_response(r_response, r_locked)),
    .i_data                (bus.data_in),
    .i_last                (w_last_beat),
    .o_rid                 (bus.RID),
    .o_rdata               (bus.RDATA),
    .o_rresp               (bus.RRESP),
    .o_rvalid              (bus.RVALID),
    .o_rlast               (bus.RLAST),
    .o_bid                 (bus.BID),
    .o_bresp               (bus.BRESP),
    .o_bvalid              (bus.BVALID)
  );

endmodule

// File: tb/tb_axi_ni_response_dispatcher.sv
// Scoreboard bench: issued headers push expected R beats / B responses, a monitor checks every handshake.
module tb_axi_ni_response_dispatcher;
  import axi_ni_response_dispatcher_pkg::*;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int IW = PACKETTRANSIDWD;
  localparam int RW = PACKETRESPONSEWD;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  axi_ni_response_dispatcher_if #(.AXIRDATAWD(DW), .BURSTLENWD(LW)) bus ();

  axi_ni_response_dispatcher #(.FLIT_WIDTH(16), .AXIRDATAWD(DW), .BURSTLENWD(LW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic          is_read;
    logic [IW-1:0] id;
    logic [RW-1:0] resp;
    logic          locked;
    logic [LW-1:0] len;
  } hdr_t;
  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } rbeat_t;
  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } bresp_t;

  hdr_t        hq[$];
  logic [DW-1:0] dq[$];
  rbeat_t      exp_r[$];
  bresp_t      exp_b[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int rready_mode = 0, dvalid_mode = 0, hvalid_mode = 0, bready_mode = 0;
  bit hold_drv = 1'b0;

  int pop_cnt = 0, r_hs_cnt = 0, b_hs_cnt = 0, b_wait_cnt = 0, b2b_r_cnt = 0;
  int last_r_hs_cyc = 0, r_burst_first_cyc = 0, b_rise_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // AXI codes: OKAY=00, EXOKAY=01, SLVERR=10
  function automatic logic [1:0] ref_resp(input logic [RW-1:0] r, input logic l);
    if (r == PKT_RESP_DVA)  return l ? 2'b01 : 2'b00;
    if (r == PKT_RESP_FAIL) return 2'b00;
    return 2'b10;
  endfunction

  task automatic issue(input logic is_read, input logic [IW-1:0] id, input logic [RW-1:0] resp,
                       input logic locked, input logic [LW-1:0] len);
    hdr_t h;
    h.is_read = is_read; h.id = id; h.resp = resp; h.locked = locked; h.len = len;
    hq.push_back(h);
    if (is_read) begin
      for (int b = 0; b <= int'(len); b++) begin
        rbeat_t e;
        e.data = $urandom;
        e.id = id; e.resp = ref_resp(resp, locked); e.last = (b == int'(len));
        dq.push_back(e.data);
        exp_r.push_back(e);
      end
    end else begin
      bresp_t e;
      e.id = id; e.resp = ref_resp(resp, locked);
      exp_b.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((hq.size() != 0 || exp_r.size() != 0 || exp_b.size() != 0) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_drain"}, 64'(n < 20000), 64'd1);
    repeat (2) @(negedge clock);
  endtask

  // Depacketizer / AXI master model
  initial begin
    bit hh, dh;
    bus.hdr_valid = 0; bus.hdr_is_read = 0; bus.hdr_id = '0; bus.hdr_response = '0;
    bus.hdr_locked = 0; bus.hdr_len = '0; bus.data_valid = 0; bus.data_in = '0;
    bus.RREADY = 0; bus.BREADY = 0;
    forever begin
      @(negedge clock);
      hh = bus.hdr_valid && bus.hdr_ready;
      dh = bus.data_valid && bus.data_pop;
      @(posedge clock);
      #1;
      if (hold_drv || !reset_n) begin
        bus.hdr_valid = 0; bus.data_valid = 0; bus.RREADY = 0; bus.BREADY = 0;
        continue;
      end
      if (hh && hq.size() != 0) void'(hq.pop_front());
      if (dh && dq.size() != 0) void'(dq.pop_front());
      if (hq.size() == 0) bus.hdr_valid = 0;
      else if (!(bus.hdr_valid && !hh)) bus.hdr_valid = (hvalid_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
      if (hq.size() != 0) begin
        bus.hdr_is_read = hq[0].is_read; bus.hdr_id = hq[0].id; bus.hdr_response = hq[0].resp;
        bus.hdr_locked = hq[0].locked; bus.hdr_len = hq[0].len;
      end
      if (dq.size() == 0) bus.data_valid = 0;
      else if (!(bus.data_valid && !dh)) bus.data_valid = (dvalid_mode == 0) ? 1'b1 : ($urandom_range(2) != 0);
      bus.data_in = (dq.size() != 0) ? dq[0] : '0;
      case (rready_mode)
        0: bus.RREADY = 1'b1;
        1: bus.RREADY = 1'($urandom_range(1));
        default: bus.RREADY = !bus.RREADY;
      endcase
      bus.BREADY = (bready_mode == 0) ? 1'b1 : (bready_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
    end
  end

  // Monitor
  initial begin
    bit prev_rv, prev_rr, prev_bv, prev_br;
    logic [DW-1:0] prev_rdata;
    logic [IW-1:0] prev_bid;
    int beat_idx;
    rbeat_t er;
    bresp_t eb;
    prev_rv = 0; prev_rr = 0; prev_bv = 0; prev_br = 0; prev_rdata = '0; prev_bid = '0; beat_idx = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_rv = 0; prev_bv = 0; beat_idx = 0;
        continue;
      end
      if (prev_rv && !prev_rr) begin
        chk("rvalid_hold", 64'(bus.RVALID), 64'd1);
        chk("rdata_hold", 64'(bus.RDATA), 64'(prev_rdata));
      end
      if (bus.data_pop || (bus.RVALID && bus.RREADY))
        chk("data_pop", 64'(bus.data_pop), 64'(bus.RVALID && bus.RREADY));
      if (bus.data_pop) pop_cnt++;
      if (bus.RVALID && bus.RREADY) begin
        r_hs_cnt++;
        last_r_hs_cyc = cyc;
        if (beat_idx == 0) r_burst_first_cyc = cyc;
        if (bus.hdr_valid && bus.hdr_ready) b2b_r_cnt++;
        if (exp_r.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
        else begin
          er = exp_r.pop_front();
          chk("r_beat", {25'd0, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST},
                        {25'd0, er.id, er.data, er.resp, er.last});
        end
        beat_idx++;
        if (bus.RLAST) begin
          $display("R burst id=%0h beats=%0d resp=%0d", bus.RID, beat_idx, bus.RRESP);
          beat_idx = 0;
        end
      end
      if (!bus.RVALID)
        chk("r_idle_zero", {25'd0, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST}, 64'd0);
      if (prev_bv && !prev_br) begin
        chk("bvalid_hold", 64'(bus.BVALID), 64'd1);
        chk("bid_hold", 64'(bus.BID), 64'(prev_bid));
      end
      if (bus.BVALID && !prev_bv) b_rise_cyc = cyc;
      if (bus.BVALID && !bus.BREADY) b_wait_cnt++;
      if (bus.BVALID && bus.BREADY) begin
        b_hs_cnt++;
        if (exp_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
        else begin
          eb = exp_b.pop_front();
          chk("b_resp", {58'd0, bus.BID, bus.BRESP}, {58'd0, eb.id, eb.resp});
        end
        $display("B id=%0h resp=%0d", bus.BID, bus.BRESP);
      end
      if (!bus.BVALID) chk("b_idle_zero", {58'd0, bus.BID, bus.BRESP}, 64'd0);
      prev_rv = bus.RVALID; prev_rr = bus.RREADY; prev_rdata = bus.RDATA;
      prev_bv = bus.BVALID; prev_br = bus.BREADY; prev_bid = bus.BID;
    end
  end

  // Sequencer
  initial begin
    int pc0, bw0, bh0, rb0, n;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rvalid", 64'(bus.RVALID), 64'd0);
    chk("reset_bvalid", 64'(bus.BVALID), 64'd0);
    chk("reset_rlast", 64'(bus.RLAST), 64'd0);
    chk("reset_data_pop", 64'(bus.data_pop), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("reset_hdr_ready", 64'(bus.hdr_ready), 64'd1);

    // 4-beat read, always ready
    pc0 = pop_cnt;
    issue(1'b1, 4'h5, PKT_RESP_DVA, 1'b0, 8'd3);
    drain("read4");
    chk("read4_pops", 64'(pop_cnt - pc0), 64'd4);
    chk("read4_consecutive", 64'(last_r_hs_cyc - r_burst_first_cyc), 64'd3);

    // Locked write with BREADY held low for 5 cycles
    bready_mode = 2;
    bw0 = b_wait_cnt; bh0 = b_hs_cnt;
    issue(1'b0, 4'h9, PKT_RESP_DVA, 1'b1, 8'd0);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.BVALID && n < 50);
    repeat (4) @(negedge clock);
    bready_mode = 0;
    drain("wr_stall");
    chk("wr_stall_wait", 64'(b_wait_cnt - bw0), 64'd5);
    chk("wr_stall_hs", 64'(b_hs_cnt - bh0), 64'd1);
    chk("wr_stall_idle", 64'(bus.hdr_ready), 64'd1);

    // 2-beat read with toggling RREADY and data gaps
    rready_mode = 2; dvalid_mode = 1;
    pc0 = pop_cnt;
    issue(1'b1, 4'h7, PKT_RESP_DVA, 1'b1, 8'd1);
    drain("read2_gaps");
    chk("read2_pops", 64'(pop_cnt - pc0), 64'd2);
    rready_mode = 0; dvalid_mode = 0;

    // Back-to-back read(len 0) then write
    rb0 = b2b_r_cnt;
    issue(1'b1, 4'h1, PKT_RESP_DVA, 1'b0, 8'd0);
    issue(1'b0, 4'h2, PKT_RESP_FAIL, 1'b0, 8'd0);
    drain("b2b");
    chk("b2b_capture", 64'(b2b_r_cnt - rb0), 64'd1);
    chk("b2b_bvalid_next", 64'(b_rise_cyc), 64'(last_r_hs_cyc + 1));

    // Reset after beat 2 of 4
    pc0 = pop_cnt;
    issue(1'b1, 4'h3, PKT_RESP_DVA, 1'b0, 8'd3);
    n = 0;
    do begin @(negedge clock); #2; n++; end while ((pop_cnt - pc0) < 2 && n < 50);
    hold_drv = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 64'(bus.RVALID), 64'd0);
    chk("rst_mid_data_pop", 64'(bus.data_pop), 64'd0);
    hq.delete(); dq.delete(); exp_r.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst_mid_hdr_ready", 64'(bus.hdr_ready), 64'd1);
    chk("rst_mid_pops", 64'(pop_cnt - pc0), 64'd2);
    @(posedge clock);
    hold_drv = 1'b0;

    // Error responses on reads
    issue(1'b1, 4'hA, PKT_RESP_ERR, 1'b0, 8'd2);
    issue(1'b1, 4'hB, PKT_RESP_DECERR, 1'b1, 8'd1);
    drain("slverr");

    // Maximum burst length
    rready_mode = 1; dvalid_mode = 1;
    issue(1'b1, 4'hC, PKT_RESP_DVA, 1'b1, 8'hFF);
    drain("max_burst");

    // Randomized mix
    hvalid_mode = 1; bready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      rready_mode = $urandom_range(2);
      issue(1'($urandom_range(1)), 4'($urandom), 2'($urandom_range(3)),
            1'($urandom_range(1)), 8'($urandom_range(7)));
    end
    drain("random");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
